hilo_bank: RTL and testbench
============================

HILO_BANK -- requirements
Module: hilo_bank

Interface
REQ-001 Parameter WIDTH, default 32: width of each of Hi and Lo; the internal HiLo register is 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles spent in WAIT; legal range >= 1.
REQ-003 clk  input  1  clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op_valid  input  1  op request strobe.
REQ-006 op  input  3  opcode: 000 NOP, 001 LOAD, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 110 CLEAR, 111 reserved.
REQ-007 op_ready  output  1  block can accept an op this cycle.
REQ-008 res_valid  input  1  mult/div result present on res_data.
REQ-009 res_data  input  2*WIDTH  mult/div result; Hi is the upper half, Lo is the lower half.
REQ-010 gpr_in  input  WIDTH  register operand for MTHI/MTLO.
REQ-011 HiOut  output  WIDTH  HiLo[2*WIDTH-1:WIDTH].
REQ-012 LoOut  output  WIDTH  HiLo[WIDTH-1:0].
REQ-013 busy  output  1  high while in WAIT.
REQ-014 timeout_err  output  1  sticky flag: a result wait expired.
REQ-015 err_clr  input  1  clears timeout_err.

Function
REQ-016 The block SHALL have two states, IDLE and WAIT, and SHALL assert op_ready combinationally only in IDLE; busy SHALL be registered and high exactly while in WAIT.
REQ-017 An op is accepted on a posedge where op_valid && op_ready; ops presented in WAIT SHALL be ignored and not queued.
REQ-018 An accepted MTHI SHALL write gpr_in to Hi and leave Lo unchanged; an accepted MTLO SHALL write gpr_in to Lo and leave Hi unchanged; an accepted CLEAR SHALL write 0 to HiLo; each of these takes effect on the accepting edge, and the block stays in IDLE.
REQ-019 NOP and the reserved opcode 111 SHALL have no effect.
REQ-020 On accepting LOAD, MADD or MSUB, the block SHALL go to WAIT, latch the opcode, and load the wait counter with TIMEOUT; HiLo is unchanged on that edge.
REQ-021 res_valid SHALL be ignored in IDLE, including on the edge that accepts the op.
REQ-022 On the first posedge in WAIT with res_valid high, the block SHALL apply the latched op and return to IDLE on that same edge.
- LOAD: HiLo <= res_data.
- MADD: HiLo <= HiLo + res_data, modulo 2^(2*WIDTH).
- MSUB: HiLo <= HiLo - res_data, modulo 2^(2*WIDTH).
REQ-023 Each posedge in WAIT without res_valid SHALL decrement the counter.
REQ-024 On an edge where the counter equals 1 and res_valid is low, the block SHALL return to IDLE, leave HiLo unchanged, and set timeout_err; the block therefore stays in WAIT for at most TIMEOUT cycles.
REQ-025 If res_valid is high on the final WAIT cycle, the result SHALL be applied and timeout_err SHALL NOT be set.
REQ-026 timeout_err SHALL stay high until err_clr is seen on a posedge; if set and clear occur on the same edge, set wins.
REQ-027 HiOut and LoOut SHALL reflect the HiLo register continuously, with no bypass of in-flight values.
REQ-028 The counter width SHALL be clog2(TIMEOUT+1) bits.

Reset
REQ-029 Assertion of reset SHALL immediately, independent of clk, force: HiLo = 0, state = IDLE, counter = 0, busy = 0, timeout_err = 0.
REQ-030 While reset is high, op_ready = 1 and all inputs are ignored.
REQ-031 Reset asserted during WAIT SHALL abandon the pending op; a res_valid arriving after reset deasserts SHALL be ignored.

Verification (WIDTH=32, TIMEOUT=4)
REQ-032 Reset, then MTHI gpr_in=0x12345678, then MTLO gpr_in=0x9ABCDEF0 -> HiOut=0x12345678, LoOut=0x9ABCDEF0; busy stays 0.
REQ-033 LOAD, then res_valid with res_data=0x00000001_FFFFFFFF two cycles later -> busy=1 for 2 cycles; HiOut=0x1, LoOut=0xFFFFFFFF.
REQ-034 With HiLo=0x00000000_FFFFFFFF, MADD with res=1 -> HiLo=0x00000001_00000000; then MSUB with res=0x00000001_00000001 -> HiLo=0xFFFFFFFF_FFFFFFFF (wrap).
REQ-035 LOAD with no res_valid -> busy high for exactly 4 cycles, then timeout_err=1 and HiLo unchanged; MTLO attempted during WAIT has no effect; err_clr -> timeout_err=0.
REQ-036 LOAD, res_valid on the 4th WAIT cycle -> result applied and timeout_err=0; res_valid on the accept edge alone -> ignored.
REQ-037 Reset pulse mid-WAIT (asynchronous, between edges) -> all outputs 0 immediately, op_ready=1; a later res_valid leaves HiLo=0.

Source files
------------

// File: rtl/hilo_bank.sv
// Hi/Lo accumulator bank: MTHI/MTLO/CLEAR act immediately, LOAD/MADD/MSUB
// wait for a mult/div result with a bounded timeout and a sticky error flag.
module hilo_bank #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [2:0]         op,
  output logic               op_ready,
  input  logic               res_valid,
  input  logic [2*WIDTH-1:0] res_data,
  input  logic [WIDTH-1:0]   gpr_in,
  output logic [WIDTH-1:0]   HiOut,
  output logic [WIDTH-1:0]   LoOut,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic { S_IDLE, S_WAIT } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_CLEAR = 3'd6,
    OP_RSVD  = 3'd7
  } opcode_e;

  state_e             state, nextState;
  opcode_e            pendOp, pendOpNext;
  logic [CW-1:0]      count, countNext;
  logic [2*WIDTH-1:0] hiLo, hiLoNext;
  logic               errSet;
  logic               accept;

  assign accept = op_valid && op_ready;

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    nextState  = state;
    pendOpNext = pendOp;
    countNext  = count;
    hiLoNext   = hiLo;
    errSet     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (opcode_e'(op))
            OP_LOAD, OP_MADD, OP_MSUB: begin
              nextState  = S_WAIT;
              pendOpNext = opcode_e'(op);
              countNext  = CW'(TIMEOUT);
            end
            OP_MTHI:  hiLoNext[2*WIDTH-1:WIDTH] = gpr_in;
            OP_MTLO:  hiLoNext[WIDTH-1:0]       = gpr_in;
            OP_CLEAR: hiLoNext                  = '0;
            default:  ;
          endcase
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          nextState = S_IDLE;
          case (pendOp)
            OP_MADD: hiLoNext = hiLo + res_data;
            OP_MSUB: hiLoNext = hiLo - res_data;
            default: hiLoNext = res_data;
          endcase
        end else begin
          countNext = count - CW'(1);
          // Last permitted cycle with no result: give up and flag it.
          if (count == CW'(1)) begin
            nextState = S_IDLE;
            errSet    = 1'b1;
          end
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pendOp      <= OP_NOP;
      count       <= '0;
      hiLo        <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state  <= nextState;
      pendOp <= pendOpNext;
      count  <= countNext;
      hiLo   <= hiLoNext;
      busy   <= (nextState == S_WAIT);
      // Setting the sticky error takes priority over clearing it.
      if (errSet)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  always_comb begin
    op_ready = (state == S_IDLE);
  end

  assign HiOut = hiLo[2*WIDTH-1:WIDTH];
  assign LoOut = hiLo[WIDTH-1:0];

endmodule

// File: tb/tb_hilo_bank.sv
// Self-checking bench for hilo_bank: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hilo_bank;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              op_valid = 1'b0;
  logic [2:0]        op = 3'd0;
  logic              op_ready;
  logic              res_valid = 1'b0;
  logic [63:0]       res_data = '0;
  logic [31:0]       gpr_in = '0;
  logic [31:0]       HiOut, LoOut;
  logic              busy, timeout_err;
  logic              err_clr = 1'b0;

  int nChecks = 0;
  int nFails  = 0;
  bit checking = 1'b0;

  hilo_bank #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .gpr_in(gpr_in),
    .HiOut(HiOut), .LoOut(LoOut), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a pending request either gets its result within
  // TIMEOUT edges after acceptance or is abandoned with the error flag set.
  logic [63:0] mHiLo = '0;
  bit          mWait = 1'b0;
  int          mLeft = 0;
  logic [2:0]  mOp = 3'd0;
  bit          mErr = 1'b0;
  bit          mExpired;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mHiLo = '0; mWait = 1'b0; mLeft = 0; mErr = 1'b0;
    end else begin
      mExpired = 1'b0;
      if (!mWait) begin
        if (op_valid) begin
          if (op == 3'd1 || op == 3'd2 || op == 3'd3) begin
            mWait = 1'b1; mOp = op; mLeft = TIMEOUT;
          end else if (op == 3'd4) mHiLo = {gpr_in, mHiLo[31:0]};
          else if (op == 3'd5) mHiLo = {mHiLo[63:32], gpr_in};
          else if (op == 3'd6) mHiLo = '0;
        end
      end else if (res_valid) begin
        if (mOp == 3'd1)      mHiLo = res_data;
        else if (mOp == 3'd2) mHiLo = mHiLo + res_data;
        else                  mHiLo = mHiLo - res_data;
        mWait = 1'b0;
      end else begin
        mLeft--;
        if (mLeft == 0) begin mWait = 1'b0; mExpired = 1'b1; end
      end
      if (mExpired)     mErr = 1'b1;
      else if (err_clr) mErr = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (checking) begin
      check("model HiOut", {32'h0, HiOut}, {32'h0, mHiLo[63:32]});
      check("model LoOut", {32'h0, LoOut}, {32'h0, mHiLo[31:0]});
      check("model busy", {63'h0, busy}, {63'h0, mWait});
      check("model op_ready", {63'h0, op_ready}, {63'h0, !mWait});
      check("model timeout_err", {63'h0, timeout_err}, {63'h0, mErr});
    end
  end

  task automatic issueOp(input logic [2:0] o, input logic [31:0] g);
    op_valid = 1'b1; op = o; gpr_in = g;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic giveRes(input logic [63:0] d);
    res_valid = 1'b1; res_data = d;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;
    check("reset HiOut", {32'h0, HiOut}, 64'h0);
    check("reset LoOut", {32'h0, LoOut}, 64'h0);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset op_ready", {63'h0, op_ready}, 64'h1);
    check("reset timeout_err", {63'h0, timeout_err}, 64'h0);

    // Register moves stay in IDLE.
    issueOp(3'd4, 32'h12345678);
    check("mthi busy", {63'h0, busy}, 64'h0);
    issueOp(3'd5, 32'h9ABCDEF0);
    check("mtlo HiOut", {32'h0, HiOut}, 64'h12345678);
    check("mtlo LoOut", {32'h0, LoOut}, 64'h9ABCDEF0);
    check("mtlo busy", {63'h0, busy}, 64'h0);

    // LOAD with result two cycles after acceptance.
    issueOp(3'd1, 32'h0);
    check("load busy c1", {63'h0, busy}, 64'h1);
    @(negedge clk);
    check("load busy c2", {63'h0, busy}, 64'h1);
    giveRes(64'h00000001_FFFFFFFF);
    check("load busy done", {63'h0, busy}, 64'h0);
    check("load HiOut", {32'h0, HiOut}, 64'h1);
    check("load LoOut", {32'h0, LoOut}, 64'hFFFFFFFF);

    // MADD carry into Hi, then MSUB wraps below zero.
    issueOp(3'd4, 32'h0);
    issueOp(3'd5, 32'hFFFFFFFF);
    issueOp(3'd2, 32'h0);
    giveRes(64'h1);
    check("madd HiLo", {HiOut, LoOut}, 64'h00000001_00000000);
    issueOp(3'd3, 32'h0);
    giveRes(64'h00000001_00000001);
    check("msub HiLo", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFFF);

    // Timeout: busy exactly TIMEOUT cycles, MTLO during WAIT ignored.
    issueOp(3'd1, 32'h0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      check("timeout busy", {63'h0, busy}, 64'h1);
      if (i == 1) issueOp(3'd5, 32'h00000055);
      else        @(negedge clk);
    end
    check("timeout busy end", {63'h0, busy}, 64'h0);
    check("timeout err set", {63'h0, timeout_err}, 64'h1);
    check("timeout HiLo kept", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFFF);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", {63'h0, timeout_err}, 64'h0);

    // res_valid on the accept edge is ignored; result on the last WAIT cycle lands.
    res_valid = 1'b1; res_data = 64'h0000DEAD_0000DEAD;
    issueOp(3'd1, 32'h0);
    res_valid = 1'b0;
    check("accept-edge res ignored", {63'h0, busy}, 64'h1);
    repeat (TIMEOUT - 1) @(negedge clk);
    giveRes(64'hCAFE0000_0000BEEF);
    check("last-cycle res HiLo", {HiOut, LoOut}, 64'hCAFE0000_0000BEEF);
    check("last-cycle res no err", {63'h0, timeout_err}, 64'h0);
    check("last-cycle res idle", {63'h0, busy}, 64'h0);

    // Accept-edge result alone must still end in a timeout.
    res_valid = 1'b1; res_data = 64'h1111;
    issueOp(3'd1, 32'h0);
    res_valid = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    check("accept-only err", {63'h0, timeout_err}, 64'h1);
    check("accept-only HiLo", {HiOut, LoOut}, 64'hCAFE0000_0000BEEF);

    // Asynchronous reset mid-WAIT abandons the pending LOAD.
    issueOp(3'd1, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("async rst HiLo", {HiOut, LoOut}, 64'h0);
    check("async rst busy", {63'h0, busy}, 64'h0);
    check("async rst op_ready", {63'h0, op_ready}, 64'h1);
    check("async rst err", {63'h0, timeout_err}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    giveRes(64'h12345678_12345678);
    check("post-rst res ignored", {HiOut, LoOut}, 64'h0);

    // Randomized traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      op_valid  = ($urandom_range(0, 1) == 1);
      op        = 3'($urandom_range(0, 7));
      gpr_in    = $urandom;
      res_valid = ($urandom_range(0, 9) < 3);
      res_data  = {$urandom, $urandom};
      err_clr   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
      @(negedge clk);
    end
    op_valid = 1'b0; res_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
